// File: rtl/ifetch_unit.sv
// Instruction-fetch sequencer: issues one request per PC, waits for the memory strobe,
// delivers the word with a one-cycle iready pulse, and traps misaligned PCs and timeouts.
module ifetch_unit #(
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] PCaddr,
  input  logic        halt,
  input  logic        irvalid,
  input  logic [31:0] irdata,
  output logic        iren,
  output logic [31:0] iaddr,
  output logic [31:0] instr,
  output logic        iready,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_ISSUE   = 2'd0,
    S_WAIT    = 2'd1,
    S_DELIVER = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state;
  logic [CW-1:0] wait_count;

  always_ff @(posedge clk) begin
    if (RST) begin
      state       <= S_ISSUE;
      iren        <= 1'b0;
      iaddr       <= '0;
      instr       <= NOP_INSTR;
      iready      <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      fetch_count <= '0;
      wait_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values and the default below is simply overridden where needed.
      iready <= 1'b0;
      unique case (state)
        S_ISSUE: begin
          if (!halt) begin
            if (PCaddr[1:0] != 2'b00) begin
              fault       <= 1'b1;
              fault_cause <= 2'b01;
              state       <= S_FAULT;
            end else begin
              iaddr      <= PCaddr;
              iren       <= 1'b1;
              wait_count <= '0;
              state      <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // halt is deliberately ignored here: an open request must finish or time out
          if (irvalid) begin
            instr       <= irdata;
            iren        <= 1'b0;
            iready      <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
            state       <= S_DELIVER;
          end else if ((TIMEOUT != 0) && (wait_count == TLAST)) begin
            iren        <= 1'b0;
            fault       <= 1'b1;
            fault_cause <= 2'b10;
            state       <= S_FAULT;
          end else begin
            wait_count <= wait_count + CW'(1);
          end
        end
        S_DELIVER: begin
          state <= S_ISSUE;
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state <= S_ISSUE;
        end
      endcase
    end
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch sequencer directly downstream of the program counter. It takes the current `PCaddr` and runs a request/valid transaction to instruction memory. It captures the returned word and pulses `iready` for exactly one cycle, which is the PC's advance enable. It also flags misaligned PCs and unresponsive memory, and counts delivered instructions.

## Interface
- `TIMEOUT`, 255: maximum WAIT cycles before a timeout fault; 0 disables the timeout. Counter width is $clog2(TIMEOUT+1), minimum 1.
- `NOP_INSTR`, 32'h0000_0013: value of `instr` after reset.

- `clk` in 1: sole clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `PCaddr` in 32: current PC from the PC register.
- `halt` in 1: when high, blocks launching a new fetch. Sampled only in ISSUE.
- `irvalid` in 1: memory read data valid, one-cycle strobe.
- `irdata` in 32: memory read data, meaningful only while `irvalid`=1.
- `iren` out 1: memory read request.
- `iaddr` out 32: memory read address.
- `instr` out 32: last delivered instruction word.
- `iready` out 1: one-cycle pulse; instruction valid, PC may advance.
- `fault` out 1: sticky fetch fault.
- `fault_cause` out 2: 00 none, 01 misaligned PC, 10 memory timeout.
- `fetch_count` out 32: number of delivered instructions; wraps.

## Operation
- FSM states are ISSUE, WAIT, DELIVER, FAULT. Reset state is ISSUE.
- Reset values (all registered):
  - `iren`=0, `iaddr`=0, `instr`=NOP_INSTR
  - `iready`=0, `fault`=0, `fault_cause`=00, `fetch_count`=0
  - timeout counter=0
- ISSUE:
  - `halt`=1: stay in ISSUE; nothing changes.
  - `halt`=0 and `PCaddr[1:0]`≠00: go to FAULT; set `fault_cause`=01; `iren` stays 0.
  - Otherwise: latch `iaddr`←`PCaddr`, set `iren`←1, clear the counter, go to WAIT.
- WAIT:
  - `iren`=1 and `iaddr` are held stable for the whole state.
  - `irvalid`=1: `instr`←`irdata`, `iren`←0, `iready`←1, `fetch_count`←`fetch_count`+1 (mod 2^32), go to DELIVER.
  - Else if TIMEOUT≠0 and counter==TIMEOUT-1: `iren`←0, `fault_cause`←10, go to FAULT.
  - Else: counter increments.
  - `halt` has no effect; an open request always completes or times out.
- DELIVER:
  - `iready`=1 for this cycle only. The PC loads its next value at the end of this cycle.
  - Go to ISSUE. `iready`←0.
- FAULT:
  - Terminal; only `RST` leaves it.
  - `fault`=1, `iren`=0, `iready`=0.
  - `instr` and `fetch_count` hold their values.
- `irvalid` is ignored in ISSUE, DELIVER and FAULT, including a stale strobe after a reset.
- `instr` changes only on WAIT→DELIVER and on reset.
- `RST` in any state, including mid-WAIT, forces all reset values on the next edge. It overrides `irvalid` and the timeout in the same cycle.

## Timing
- ISSUE in cycle t: `iren`=1 and `iaddr` valid from cycle t+1.
- `irvalid` sampled high in WAIT cycle t+L (L≥1, where L=1 is a zero-wait memory): `iready`=1 and new `instr` in cycle t+L+1. ISSUE again in cycle t+L+2.
- Minimum throughput is 3 cycles per instruction. `iready` is never high on two consecutive cycles.
- Timeout: with no `irvalid`, WAIT lasts exactly TIMEOUT cycles (t+1..t+TIMEOUT). FAULT is entered with `fault`=1 in cycle t+TIMEOUT+1.
- Misalignment: ISSUE with a bad PC in cycle t gives `fault`=1 in cycle t+1. `iren` never rises.
- Reset asserted in cycle r: outputs hold their reset values from cycle r+1. The first ISSUE is the first cycle after `RST` falls.

## Test plan
- Reset, PCaddr=0, memory answers `irvalid` 1 cycle after `iren` with 32'h00500093:
  - `iaddr`=0.
  - `iready` pulses once, 3 cycles after ISSUE.
  - `instr`=32'h00500093, `fetch_count`=1.
  - Next fetch `iaddr`=4.
- Memory latency of 5 WAIT cycles, repeated over 10 fetches:
  - `iready` every 7 cycles.
  - `iren`/`iaddr` stable throughout each WAIT.
  - `fetch_count`=10.
- PCaddr=32'h0000_0102 → `fault`=1 and `fault_cause`=01 in the next cycle. `iren` never asserted; state stuck until `RST`.
- TIMEOUT=4, no `irvalid`:
  - `iren` high exactly 4 cycles.
  - Then `fault_cause`=10, `iready` never pulses, `instr` stays 32'h00000013.
- `halt`=1 for 6 cycles in ISSUE: `iren` stays 0. Release `halt` → request starts next cycle. `halt` raised during WAIT does not drop `iren`.
- `RST` pulsed mid-WAIT, then `irvalid` strobed the cycle after:
  - Strobe ignored, `instr`=NOP, `fetch_count`=0.
  - Fresh ISSUE follows.
- Bonus check: preload `fetch_count` to 32'hFFFF_FFFF via force → wraps to 0 on the next delivery.
